// File: rtl/tcm_axis_pkg.sv
// tcm_axis_pkg: shared types and constants
// for the TCM-to-AXI-Stream transmit block.
package tcm_axis_pkg;

  localparam int TDATA_W   = 32;
  localparam int TCM_DEPTH = 32;
  localparam int TCM_AW    = 5;
  localparam int LEN_W     = TCM_AW + 1;

  localparam logic [TDATA_W/8-1:0] TSTRB_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] l
  );
    if (l > LEN_W'(TCM_DEPTH))
      return LEN_W'(TCM_DEPTH);
    return l;
  endfunction

endpackage

// File: rtl/tcm_axis_out_skid.sv
// tcm_axis_out_skid: 2-entry {last,data} buffer
// whose head drives the AXI-Stream outputs.
module tcm_axis_out_skid
  import tcm_axis_pkg::*;
#(
  parameter int W = TDATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last
);

  logic [W:0] ent [2];
  logic       wp;
  logic       rp;
  logic [1:0] cnt;
  logic       pop_ok;

  assign pop_ok      = pop && (cnt != 2'd0);
  assign full        = (cnt == 2'd2);
  assign almost_full = (cnt == 2'd1);
  assign empty       = (cnt == 2'd0);
  assign valid       = !empty;
  assign data        = ent[rp][W-1:0];
  // stale head may hold last=1 after a packet
  assign last        = valid && ent[rp][W];

  always_ff @(posedge clk) begin
    if (rst) begin
      ent[0] <= '0;
      ent[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        ent[wp] <= {push_last, push_data};
        wp      <= ~wp;
      end
      if (pop_ok)
        rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/tcm_axis_stream_out.sv
// tcm_axis_stream_out: streams a host-loaded TCM
// out as one AXI-Stream packet per start edge.
module tcm_axis_stream_out
  import tcm_axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = TDATA_W,
  parameter int C_TCM_DEPTH          = TCM_DEPTH,
  parameter int C_TCM_ADDR_WIDTH     = TCM_AW
) (
  input  logic M_AXIS_ACLK,
  input  logic M_AXIS_ARESET,
  input  logic USR_tcm_wr_en,
  input  logic [C_TCM_ADDR_WIDTH-1:0]
               USR_tcm_wr_addr,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]
               USR_tcm_wr_data,
  input  logic USR_tcm_start,
  input  logic [C_TCM_ADDR_WIDTH:0]
               USR_tcm_length,
  output logic tcm_busy,
  output logic tcm_done,
  output logic [C_TCM_ADDR_WIDTH-1:0]
               tcm_rd_addr_out,
  output logic M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]
               M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]
               M_AXIS_TSTRB,
  output logic M_AXIS_TLAST,
  input  logic M_AXIS_TREADY
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int AW = C_TCM_ADDR_WIDTH;
  localparam int LW = AW + 1;

  logic [DW-1:0] tcm [C_TCM_DEPTH];

  state_t        state;
  state_t        state_nx;
  logic          start_d;
  logic          done_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] rd_cnt;
  logic [LW-1:0] beat_cnt;
  logic [AW-1:0] rd_addr;
  logic          rd_pend;
  logic          rd_last;
  logic [DW-1:0] rd_data;

  logic start_ok;
  logic issue;
  logic pop;
  logic last_pop;
  logic slot_ok;
  logic sk_full;
  logic sk_empty;
  logic sk_afull;

  assign start_ok = (state == IDLE)
                 && USR_tcm_start
                 && !start_d
                 && (USR_tcm_length != '0);
  assign pop      = M_AXIS_TVALID
                 && M_AXIS_TREADY;
  assign last_pop = pop
                 && (beat_cnt == len_q - LW'(1));

  // a read lands in the buffer one cycle after
  // issue, so leave room for it and any pending
  assign slot_ok = sk_empty
                || (sk_afull && (!rd_pend || pop))
                || (sk_full && pop && !rd_pend);

  assign tcm_busy        = (state != IDLE);
  assign tcm_done        = done_q;
  assign tcm_rd_addr_out = rd_addr;
  assign M_AXIS_TSTRB    = TSTRB_ONES;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok)
          state_nx = FILL;
      end
      FILL: begin
        issue    = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        issue = (rd_cnt < len_q) && slot_ok;
        if (last_pop)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state    <= IDLE;
      start_d  <= 1'b0;
      done_q   <= 1'b0;
      len_q    <= '0;
      rd_cnt   <= '0;
      beat_cnt <= '0;
      rd_addr  <= '0;
      rd_pend  <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      state   <= state_nx;
      start_d <= USR_tcm_start;
      rd_pend <= issue;
      rd_last <= issue
              && (rd_cnt == len_q - LW'(1));
      if (start_ok) begin
        len_q    <= clamp_len(USR_tcm_length);
        done_q   <= 1'b0;
        rd_cnt   <= '0;
        beat_cnt <= '0;
        rd_addr  <= '0;
      end
      if (issue) begin
        rd_cnt  <= rd_cnt + LW'(1);
        rd_addr <= rd_cnt[AW-1:0];
      end
      if (pop)
        beat_cnt <= beat_cnt + LW'(1);
      if (last_pop)
        done_q <= 1'b1;
    end
  end

  // read-first BRAM, contents survive reset
  always_ff @(posedge M_AXIS_ACLK) begin
    if (USR_tcm_wr_en)
      tcm[USR_tcm_wr_addr] <= USR_tcm_wr_data;
    if (issue)
      rd_data <= tcm[rd_cnt[AW-1:0]];
  end

  tcm_axis_out_skid #(
    .W (DW)
  ) u_skid (
    .clk         (M_AXIS_ACLK),
    .rst         (M_AXIS_ARESET),
    .push        (rd_pend),
    .push_data   (rd_data),
    .push_last   (rd_last),
    .pop         (pop),
    .full        (sk_full),
    .empty       (sk_empty),
    .almost_full (sk_afull),
    .valid       (M_AXIS_TVALID),
    .data        (M_AXIS_TDATA),
    .last        (M_AXIS_TLAST)
  );

endmodule
